// File: rtl/ps2_note_tracker.sv
// ps2_note_tracker: PS/2 set-2 scan-code sequencer mapping 16 keys to notes with held-key tracking.
// Optional inter-byte timeout is compiled in with `define PS2_TIMEOUT_EN.
module ps2_note_tracker #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iFlag,
  input  logic [7:0]  iData,
  output logic        oNoteValid,
  output logic [3:0]  oNote,
  output logic        oPress,
  output logic [15:0] oKeyMask,
  output logic        oActive,
  output logic [3:0]  oCurNote
);
  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;
  state_t      r_state, w_state_nxt;
  logic        r_flag_d, w_acc, w_hit, w_timeout, w_make, w_brk;
  logic [3:0]  w_idx, w_hi, r_cur, w_cur_nxt;
  logic [15:0] w_rem;
  assign w_acc = iFlag & ~r_flag_d;
  always_comb begin
    w_hit = 1'b1;
    w_idx = 4'd0;
    case (iData)
      8'h1C: w_idx = 4'd0;
      8'h1D: w_idx = 4'd1;
      8'h1B: w_idx = 4'd2;
      8'h24: w_idx = 4'd3;
      8'h23: w_idx = 4'd4;
      8'h2B: w_idx = 4'd5;
      8'h2C: w_idx = 4'd6;
      8'h34: w_idx = 4'd7;
      8'h35: w_idx = 4'd8;
      8'h33: w_idx = 4'd9;
      8'h3C: w_idx = 4'd10;
      8'h3B: w_idx = 4'd11;
      8'h42: w_idx = 4'd12;
      8'h44: w_idx = 4'd13;
      8'h4B: w_idx = 4'd14;
      8'h4D: w_idx = 4'd15;
      default: w_hit = 1'b0;
    endcase
  end
`ifdef PS2_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;
  assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge iClk or negedge iReset_n)
    if (!iReset_n) r_to_cnt <= '0;
    else r_to_cnt <= (w_acc || r_state == S_IDLE || w_timeout) ? '0 : r_to_cnt + 1'b1;
`else
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif
  always_ff @(posedge iClk or negedge iReset_n)
    if (!iReset_n) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  // An accepted byte always takes priority over a timeout in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    if (w_acc)
      case (r_state)
        S_IDLE:  w_state_nxt = (iData == 8'hE0) ? S_EXT : (iData == 8'hF0) ? S_BRK : S_IDLE;
        S_EXT:   w_state_nxt = (iData == 8'hF0) ? S_EXT_BRK : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    else if (w_timeout)
      w_state_nxt = S_IDLE;
  end
  always_comb begin
    w_make = w_acc && r_state == S_IDLE && w_hit && !oKeyMask[w_idx];
    w_brk  = w_acc && r_state == S_BRK  && w_hit &&  oKeyMask[w_idx];
    w_rem  = oKeyMask & ~(16'd1 << w_idx);
    w_hi   = 4'd0;
    for (int i = 0; i < 16; i++)
      if (w_rem[i]) w_hi = 4'(i);
    w_cur_nxt = w_make ? w_idx : (w_brk && w_idx == r_cur && |w_rem) ? w_hi : r_cur;
  end
  always_ff @(posedge iClk or negedge iReset_n)
    if (!iReset_n) begin
      r_flag_d   <= 1'b0;
      oNoteValid <= 1'b0;
      oNote      <= 4'd0;
      oPress     <= 1'b0;
      oKeyMask   <= 16'd0;
      r_cur      <= 4'd0;
    end else begin
      r_flag_d   <= iFlag;
      oNoteValid <= w_make | w_brk;
      r_cur      <= w_cur_nxt;
      if (w_make | w_brk) begin
        oNote  <= w_idx;
        oPress <= w_make;
      end
      if (w_make) oKeyMask <= oKeyMask | (16'd1 << w_idx);
      else if (w_brk) oKeyMask <= w_rem;
    end
  assign oActive  = |oKeyMask;
  assign oCurNote = r_cur;
endmodule

// File: tb/tb_ps2_note_tracker.sv
// tb_ps2_note_tracker: randomized self-checking bench with a prefix-queue reference model.
module tb_ps2_note_tracker;
  logic        iClk = 1'b0, iReset_n = 1'b0, iFlag = 1'b0;
  logic [7:0]  iData = 8'h00;
  logic        oNoteValid, oPress, oActive;
  logic [3:0]  oNote, oCurNote;
  logic [15:0] oKeyMask;
  int n_vec = 0, n_err = 0;
  ps2_note_tracker #(.TIMEOUT_CYCLES(100)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iFlag(iFlag), .iData(iData),
    .oNoteValid(oNoteValid), .oNote(oNote), .oPress(oPress),
    .oKeyMask(oKeyMask), .oActive(oActive), .oCurNote(oCurNote)
  );
  always #5 iClk = ~iClk;
  logic [7:0]  keys [16] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34,
                             8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42, 8'h44, 8'h4B, 8'h4D};
  logic [7:0]  q [$];
  logic [15:0] m_mask;
  logic [3:0]  m_cur, m_note;
  logic        m_press, m_ev;
  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < 16; i++) if (keys[i] == b) return i;
    return -1;
  endfunction
  task automatic model_clear();
    q.delete();
    m_mask = '0; m_cur = '0; m_note = '0; m_press = 1'b0; m_ev = 1'b0;
  endtask
  // A sequence is the pending prefix bytes plus the final byte that completes it
  task automatic model_byte(input logic [7:0] b);
    int n;
    n = lookup(b);
    m_ev = 1'b0;
    if (q.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) q.push_back(b);
      else if (n >= 0 && !m_mask[n]) begin
        m_mask[n] = 1'b1; m_cur = 4'(n); m_note = 4'(n); m_press = 1'b1; m_ev = 1'b1;
      end
    end else if (q.size() == 1 && q[0] == 8'hF0) begin
      if (n >= 0 && m_mask[n]) begin
        m_mask[n] = 1'b0; m_note = 4'(n); m_press = 1'b0; m_ev = 1'b1;
        if (m_cur == 4'(n) && m_mask != 0)
          for (int k = 15; k >= 0; k--) if (m_mask[k]) begin m_cur = 4'(k); break; end
      end
      q.delete();
    end else if (q.size() == 1 && b == 8'hF0) q.push_back(b);
    else q.delete();
  endtask
  task automatic do_reset();
    iFlag = 1'b0; iReset_n = 1'b0;
    @(negedge iClk); @(negedge iClk);
    iReset_n = 1'b1;
    model_clear();
  endtask
  // Presents one byte for `hold` cycles, then a low gap; checks every cycle
  task automatic send(input logic [7:0] b, input int hold = 1, input int gap = 1);
    iData = b; iFlag = 1'b1;
    model_byte(b);
    @(negedge iClk);
    n_vec++;
    if ({oNoteValid, oNote, oPress, oKeyMask, oActive, oCurNote} !==
        {m_ev, m_note, m_press, m_mask, |m_mask, m_cur}) begin
      n_err++;
      $display("FAIL byte %h: got v=%b n=%0d p=%b m=%h a=%b c=%0d want v=%b n=%0d p=%b m=%h a=%b c=%0d",
               b, oNoteValid, oNote, oPress, oKeyMask, oActive, oCurNote,
               m_ev, m_note, m_press, m_mask, |m_mask, m_cur);
    end
    for (int i = 0; i < hold - 1 + gap; i++) begin
      if (i == hold - 1) iFlag = 1'b0;
      @(negedge iClk);
      n_vec++;
      if (oNoteValid !== 1'b0 || oKeyMask !== m_mask) begin
        n_err++;
        $display("FAIL quiet after %h: got v=%b m=%h want v=0 m=%h", b, oNoteValid, oKeyMask, m_mask);
      end
    end
    iFlag = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({oNoteValid, oNote, oPress, oKeyMask, oActive, oCurNote} !== 27'd0) begin
      n_err++; $display("FAIL reset_state: got %h want 0", {oNoteValid, oNote, oPress, oKeyMask, oActive, oCurNote});
    end
    send(8'h1C); send(8'hF0);
    #2 iReset_n = 1'b0; #1;
    n_vec++;
    if ({oNoteValid, oNote, oPress, oKeyMask, oActive, oCurNote} !== 27'd0) begin
      n_err++; $display("FAIL mid_reset: got %h want 0", {oNoteValid, oNote, oPress, oKeyMask, oActive, oCurNote});
    end
    @(negedge iClk); iReset_n = 1'b1; model_clear();
    send(8'h1C);
    n_vec++;
    if (oKeyMask !== 16'h0001) begin
      n_err++; $display("FAIL reset_then_press: got mask %h want 0001", oKeyMask);
    end
  endtask
  task automatic test_press_release();
    do_reset();
    send(8'h1C); send(8'hF0); send(8'h1C);
    n_vec++;
    if (oKeyMask !== 16'h0 || oActive !== 1'b0 || oCurNote !== 4'd0 || oPress !== 1'b0) begin
      n_err++; $display("FAIL release: got m=%h a=%b c=%0d p=%b want 0 0 0 0", oKeyMask, oActive, oCurNote, oPress);
    end
  endtask
  task automatic test_typematic();
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C);
    n_vec++;
    if (oKeyMask !== 16'h0001 || q.size() != 0) begin
      n_err++; $display("FAIL typematic: got mask %h want 0001", oKeyMask);
    end
  endtask
  task automatic test_cur_note();
    do_reset();
    send(8'h1C); send(8'h4D); send(8'h23);
    n_vec++;
    if (oCurNote !== 4'd4) begin n_err++; $display("FAIL cur_a: got %0d want 4", oCurNote); end
    send(8'hF0); send(8'h23);
    n_vec++;
    if (oCurNote !== 4'd15) begin n_err++; $display("FAIL cur_b: got %0d want 15", oCurNote); end
    send(8'hF0); send(8'h4D);
    n_vec++;
    if (oCurNote !== 4'd0) begin n_err++; $display("FAIL cur_c: got %0d want 0", oCurNote); end
  endtask
  task automatic test_stretch();
    do_reset();
    send(8'h1B, 5, 1);
    n_vec++;
    if (oNote !== 4'd2 || oKeyMask !== 16'h0004) begin
      n_err++; $display("FAIL stretch: got n=%0d m=%h want 2 0004", oNote, oKeyMask);
    end
    send(8'h5A);
  endtask
  task automatic test_timeout();
    logic exp;
    do_reset();
    send(8'hF0, 1, 150);
`ifdef PS2_TIMEOUT_EN
    q.delete(); exp = 1'b1;
`else
    exp = 1'b0;
`endif
    send(8'h1C);
    n_vec++;
    if (oKeyMask[0] !== exp) begin
      n_err++; $display("FAIL timeout: got held=%b want %b", oKeyMask[0], exp);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 60; i++) send(keys[$urandom_range(15)]);
  endtask
  task automatic test_random();
    logic [7:0] b;
    int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      b = (r < 55) ? keys[$urandom_range(15)] : (r < 65) ? 8'hE0 : (r < 85) ? 8'hF0 : 8'($urandom);
      send(b, $urandom_range(1, 3), $urandom_range(1, 3));
    end
  endtask
  initial begin
    model_clear();
    test_reset();
    test_press_release();
    test_typematic();
    test_cur_note();
    test_stretch();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
